seg7_scan_ctrl: RTL and testbench

//   Multiplexed seven-segment scan controller. Divides clk into per-digit time slots,

---
 rtl/seg7_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- multiplexed seven-segment scan controller.
//
// Splits clk into per-digit time slots of TICK_DIV clocks, enables one
// active-low anode per slot and decodes that digit's hex nibble onto the
// active-low segment bus. The first DEAD_CYCLES clocks of every slot are
// blanked so the previous digit's segments never ghost onto the new anode.
// New display words arrive through a valid/ready shadow register and are
// copied into the displayed (active) register only at a frame boundary or
// when scanning starts from idle, so a frame never shows a torn word.
//
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero suppression.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   en_i           scan enable (0 = display dark, scan position reset)
//   data_i         hex nibbles, data_i[3:0] is digit 0 (rightmost)
//   dp_i           decimal points, 1 = lit
//   valid_i        data_i/dp_i valid
//   ready_o        shadow register free
//   anode_o        active-low anode enables, anode_o[i] = digit i
//   seg_o          active-low segments {g,f,e,d,c,b,a}
//   dp_o           active-low decimal point
//   digit_idx_o    index of the current slot
//   frame_done_o   1-clk pulse on the last clock of digit N_DIGITS-1
//   state_o        FSM state (0 idle, 1 blank, 2 show) for observation
//
// Handshake: a word is taken on any rising clk edge where valid_i and
// ready_o are both 1. ready_o is registered and falls the clock after a
// capture; it rises again the clock after that word moves to the active
// register. valid_i while ready_o is 0 is ignored and the shadow is kept.
module seg7_scan_ctrl #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SCAN_FREQ   = 1_000,
  parameter int N_DIGITS    = 4,
  parameter int DEAD_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [N_DIGITS-1:0]   anode_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [2:0]            digit_idx_o,
  output logic                  frame_done_o,
  output logic [1:0]            state_o
);

  localparam int TICK_DIV = CLK_FREQ / (SCAN_FREQ * N_DIGITS);
  localparam int CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [N_DIGITS-1:0]   sdp_q, sdp_d, adp_q, adp_d;
  logic                  pending_q, pending_d;

  logic                  wrap, start;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [3:0]            nib_sel;
  logic                  dp_sel, lz_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Next state, scan position and handshake registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    sdp_d     = sdp_q;
    active_d  = active_q;
    adp_d     = adp_q;
    pending_d = pending_q;

    wrap  = en_i && (state_q == S_SHOW) && (cnt_q == CNT_MAX) && (idx_q == IDX_LAST);
    start = en_i && (state_q == S_IDLE);

    if (!en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DEAD_LAST) state_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q == CNT_MAX) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Capture needs pending=0 and transfer needs pending=1, so they are exclusive.
    if (valid_i && !pending_q) begin
      shadow_d  = data_i;
      sdp_d     = dp_i;
      pending_d = 1'b1;
    end else if (pending_q && (wrap || start)) begin
      active_d  = shadow_q;
      adp_d     = sdp_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      sdp_q     <= '0;
      active_q  <= '0;
      adp_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      sdp_q     <= sdp_d;
      active_q  <= active_d;
      adp_q     <= adp_d;
      pending_q <= pending_d;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // Walk from the leftmost digit down; a digit is blanked while every
  // nibble from the top down to it is zero. Digit 0 always shows.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero & (active_q[4*i +: 4] == 4'h0);
      lz_blank[i] = all_zero && (i != 0);
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Outputs decode straight from registered state so reset darkens them at once.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    lz_sel  = 1'b0;
    anode_o = '1;
    seg_o   = 7'h7F;
    dp_o    = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        nib_sel = active_q[4*i +: 4];
        dp_sel  = adp_q[i];
        lz_sel  = lz_blank[i];
      end
    end
    if (state_q == S_SHOW) begin
      for (int i = 0; i < N_DIGITS; i++) anode_o[i] = (idx_q != 3'(i));
      seg_o = lz_sel ? 7'h7F : hex7(nib_sel);
      dp_o  = ~dp_sel;
    end
  end

  assign ready_o      = ~pending_q;
  assign digit_idx_o  = idx_q;
  assign frame_done_o = wrap;
  assign state_o      = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with CLK_FREQ=1000, SCAN_FREQ=50, N_DIGITS=4,
// DEAD_CYCLES=1 (5-clock slots). The reference model tracks time elapsed
// since scanning started and derives slot and position arithmetically.
module tb_seg7_scan_ctrl;

  localparam int CF = 1000;
  localparam int SF = 50;
  localparam int ND = 4;
  localparam int DC = 1;
  localparam int TD = CF / (SF * ND);

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  dp_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [2:0]  digit_idx_o;
  logic        frame_done_o;
  logic [1:0]  state_dbg;

  seg7_scan_ctrl #(
    .CLK_FREQ(CF), .SCAN_FREQ(SF), .N_DIGITS(ND), .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .data_i(data_i), .dp_i(dp_i),
    .valid_i(valid_i), .ready_o(ready_o), .anode_o(anode_o), .seg_o(seg_o),
    .dp_o(dp_o), .digit_idx_o(digit_idx_o), .frame_done_o(frame_done_o),
    .state_o(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;

  // Reference model state
  bit          m_run;
  int          m_t;
  logic [15:0] m_shadow, m_active;
  logic [3:0]  m_sdp, m_adp;
  bit          m_pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_t = 0; m_shadow = '0; m_active = '0;
    m_sdp = '0; m_adp = '0; m_pending = 0;
  endfunction

  function automatic void model_edge();
    bit wrap, start;
    wrap  = m_run && en_i && (m_t % TD == TD - 1) && ((m_t / TD) % ND == ND - 1);
    start = !m_run && en_i;
    if (valid_i && !m_pending) begin
      m_shadow = data_i; m_sdp = dp_i; m_pending = 1;
    end else if (m_pending && (wrap || start)) begin
      m_active = m_shadow; m_adp = m_sdp; m_pending = 0;
    end
    if (!en_i) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t = m_t + 1;
    end
  endfunction

  task automatic check_outputs();
    int slot, pos;
    logic [3:0] exp_an, nib;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_fd;
    logic [2:0] exp_idx;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0; exp_idx = 3'd0;
    if (m_run) begin
      slot = (m_t / TD) % ND;
      pos  = m_t % TD;
      exp_idx = 3'(slot);
      if (pos >= DC) begin
        exp_an  = ~(4'b0001 << slot);
        nib     = 4'((m_active >> (4 * slot)) & 16'hF);
        exp_seg = HEX_TAB[nib];
`ifdef SEG7_LZ_BLANK_EN
        if (slot != 0 && (m_active >> (4 * slot)) == 16'h0) exp_seg = 7'h7F;
`endif
        exp_dp = ~m_adp[slot];
      end
      exp_fd = en_i && (pos == TD - 1) && (slot == ND - 1);
    end
    chk("anode", 32'(anode_o), 32'(exp_an));
    chk("seg", 32'(seg_o), 32'(exp_seg));
    chk("dp", 32'(dp_o), 32'(exp_dp));
    chk("idx", 32'(digit_idx_o), 32'(exp_idx));
    chk("frame_done", 32'(frame_done_o), 32'(exp_fd));
    chk("ready", 32'(ready_o), 32'(!m_pending));
    fd_cnt += int'(frame_done_o);
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_pos(input int s, input int p);
    int k = 0;
    while (!(m_run && (m_t / TD) % ND == s && m_t % TD == p) && k < 100) begin
      step();
      k++;
    end
    chk("wait_budget", 32'(k < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mask;
    model_reset();
    // Reset state (async)
    #1 rst = 1'b1;
    #1 check_outputs();
    step(); step();
    rst = 1'b0;
    step();

    // Load 1234, then enable: 1 blank clk, then digit 0 shows 4
    data_i = 16'h1234; dp_i = 4'b0010; valid_i = 1'b1;
    step();
    chk("t2_ready_low", 32'(ready_o), 32'd0);
    valid_i = 1'b0; en_i = 1'b1;
    step();
    chk("t2_blank_anode", 32'(anode_o), 32'hF);
    chk("t2_ready_high", 32'(ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_show_anode", 32'(anode_o), 32'b1110);
      chk("t2_show_seg", 32'(seg_o), 32'h19);
    end

    // 20 clocks contain exactly one frame_done pulse
    fd_cnt = 0;
    repeat (20) step();
    chk("t3_frame_done_once", 32'(fd_cnt), 32'd1);

    // Load ABCD mid-frame; held FFFF ignored; D appears next frame
    wait_pos(2, 2);
    data_i = 16'hABCD; valid_i = 1'b1;
    step();
    chk("t4_ready_low", 32'(ready_o), 32'd0);
    data_i = 16'hFFFF;
    repeat (6) step();
    valid_i = 1'b0;
    wait_pos(0, 1);
    chk("t4_digit0_D", 32'(seg_o), 32'h21);

    // en_i drop at cnt 3 of digit 1
    wait_pos(1, 3);
    en_i = 1'b0;
    step();
    chk("t5_dark", 32'(anode_o), 32'hF);
    chk("t5_idx0", 32'(digit_idx_o), 32'd0);
    en_i = 1'b1;
    step();
    chk("t5_blank", 32'(anode_o), 32'hF);
    step();
    chk("t5_digit0", 32'(anode_o), 32'b1110);

    // Leading zeros
    data_i = 16'h0070; dp_i = 4'b0000; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    wait_pos(0, 1);
    chk("t6_d0", 32'(seg_o), 32'h40);
    wait_pos(1, 1);
    chk("t6_d1", 32'(seg_o), 32'h78);
    wait_pos(2, 1);
`ifdef SEG7_LZ_BLANK_EN
    chk("t6_d2", 32'(seg_o), 32'h7F);
`else
    chk("t6_d2", 32'(seg_o), 32'h40);
`endif
    wait_pos(3, 1);
`ifdef SEG7_LZ_BLANK_EN
    chk("t6_d3", 32'(seg_o), 32'h7F);
`else
    chk("t6_d3", 32'(seg_o), 32'h40);
`endif

    // Async reset mid-operation discards a pending word
    data_i = 16'h9999; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    chk("rst_async_dark", 32'(anode_o), 32'hF);
    step();
    rst = 1'b0;
    repeat (25) step();

    // Randomized phase
    repeat (800) begin
      en_i    = ($urandom_range(0, 19) != 0);
      valid_i = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        3: mask = 16'h0FFF;
        default: mask = 16'h0000;
      endcase
      data_i = 16'($urandom) & mask;
      dp_i   = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1 model_reset();
        check_outputs();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
